// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared phase codes, seconds width and transition rules for the traffic light monitor
package tl_pkg;

  localparam int SECS_W = 5;
  localparam logic [SECS_W-1:0] SECS_MAX = 5'd31;

  typedef enum logic [2:0] {
    PH_NONE        = 3'd0,
    PH_ALL_RED     = 3'd1,
    PH_MAIN_GREEN  = 3'd2,
    PH_MAIN_YELLOW = 3'd3,
    PH_SIDE_GREEN  = 3'd4,
    PH_SIDE_YELLOW = 3'd5,
    PH_WALK        = 3'd6,
    PH_ILLEGAL     = 3'd7
  } phase_e;

  function automatic logic is_legal_phase(input phase_e p);
    return (p != PH_NONE) && (p != PH_ILLEGAL);
  endfunction

  function automatic logic transition_ok(input phase_e old_p, input phase_e new_p);
    logic ok;
    ok = 1'b0;
    case (old_p)
      PH_ALL_RED:     ok = (new_p == PH_MAIN_GREEN);
      PH_MAIN_GREEN:  ok = (new_p == PH_MAIN_YELLOW);
      PH_MAIN_YELLOW: ok = (new_p == PH_SIDE_GREEN) || (new_p == PH_WALK);
      PH_WALK:        ok = (new_p == PH_SIDE_GREEN);
      PH_SIDE_GREEN:  ok = (new_p == PH_SIDE_YELLOW);
      PH_SIDE_YELLOW: ok = (new_p == PH_MAIN_GREEN);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// rtl/tl_phase_decode.sv - combinational lamp pattern to phase code decode
module tl_phase_decode
  import tl_pkg::*;
(
  input  logic   Rm,
  input  logic   Ym,
  input  logic   Gm,
  input  logic   Rs,
  input  logic   Ys,
  input  logic   Gs,
  input  logic   W,
  output phase_e phase
);

  // Bit order {Rm,Ym,Gm,Rs,Ys,Gs,W}; anything not listed is a conflict.
  always_comb begin
    phase = PH_ILLEGAL;
    case ({Rm, Ym, Gm, Rs, Ys, Gs, W})
      7'b000_000_0: phase = PH_NONE;
      7'b100_100_0: phase = PH_ALL_RED;
      7'b001_100_0: phase = PH_MAIN_GREEN;
      7'b010_100_0: phase = PH_MAIN_YELLOW;
      7'b100_001_0: phase = PH_SIDE_GREEN;
      7'b100_010_0: phase = PH_SIDE_YELLOW;
      7'b100_100_1: phase = PH_WALK;
      default:      phase = PH_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - phase tracking, sequence check and timing of lamp drives
// Optional sticky fault indication on fail_safe when TLM_FAULT_LATCH_EN is defined.
module traffic_light_monitor
  import tl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              one_hz_enable,
  input  logic              Rm,
  input  logic              Ym,
  input  logic              Gm,
  input  logic              Rs,
  input  logic              Ys,
  input  logic              Gs,
  input  logic              W,
  output logic [2:0]        phase,
  output logic              phase_change,
  output logic [SECS_W-1:0] phase_secs,
  output logic [SECS_W-1:0] last_secs,
  output logic              conflict,
  output logic              sequence_err,
  output logic              fail_safe
);

  logic [6:0]        lamps_q, lamps_d;
  phase_e            phase_q, phase_d;
  phase_e            dec_phase;
  logic              phase_change_q, phase_change_d;
  logic              sequence_err_q, sequence_err_d;
  logic [SECS_W-1:0] phase_secs_q, phase_secs_d;
  logic [SECS_W-1:0] last_secs_q, last_secs_d;

  tl_phase_decode u_decode (
    .Rm    (lamps_q[6]),
    .Ym    (lamps_q[5]),
    .Gm    (lamps_q[4]),
    .Rs    (lamps_q[3]),
    .Ys    (lamps_q[2]),
    .Gs    (lamps_q[1]),
    .W     (lamps_q[0]),
    .phase (dec_phase)
  );

  always_comb begin
    lamps_d        = {Rm, Ym, Gm, Rs, Ys, Gs, W};
    phase_d        = phase_q;
    phase_change_d = 1'b0;
    sequence_err_d = 1'b0;
    phase_secs_d   = phase_secs_q;
    last_secs_d    = last_secs_q;

    if (dec_phase != phase_q) begin
      phase_d        = dec_phase;
      phase_change_d = 1'b1;
      // Only legal-to-legal moves are judged; NONE/ILLEGAL endpoints are exempt.
      sequence_err_d = is_legal_phase(phase_q) && is_legal_phase(dec_phase) &&
                       !transition_ok(phase_q, dec_phase);
      last_secs_d    = phase_secs_q;
      phase_secs_d   = '0;
    end else if (one_hz_enable && (phase_secs_q != SECS_MAX)) begin
      phase_secs_d   = phase_secs_q + SECS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lamps_q        <= '0;
      phase_q        <= PH_NONE;
      phase_change_q <= 1'b0;
      sequence_err_q <= 1'b0;
      phase_secs_q   <= '0;
      last_secs_q    <= '0;
    end else begin
      lamps_q        <= lamps_d;
      phase_q        <= phase_d;
      phase_change_q <= phase_change_d;
      sequence_err_q <= sequence_err_d;
      phase_secs_q   <= phase_secs_d;
      last_secs_q    <= last_secs_d;
    end
  end

  assign phase        = phase_q;
  assign phase_change = phase_change_q;
  assign sequence_err = sequence_err_q;
  assign phase_secs   = phase_secs_q;
  assign last_secs    = last_secs_q;
  assign conflict     = (phase_q == PH_ILLEGAL);

`ifdef TLM_FAULT_LATCH_EN
  logic fail_safe_q, fail_safe_d;

  always_comb begin
    fail_safe_d = fail_safe_q | conflict | sequence_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_safe_q <= 1'b0;
    end else begin
      fail_safe_q <= fail_safe_d;
    end
  end

  assign fail_safe = fail_safe_q;
`else
  assign fail_safe = 1'b0;
`endif

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have ports: clk  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: one_hz_enable  in  1  single-cycle 1 Hz tick, synchronous to clk.
REQ-004 SHALL have ports: Rm, Ym, Gm, Rs, Ys, Gs, W  in  1 each  lamp drives from the controller (main R/Y/G, side R/Y/G, walk).
REQ-005 SHALL have ports: phase  out  3  decoded phase code.
REQ-006 SHALL have ports: phase_change  out  1  one-cycle pulse when phase updates.
REQ-007 SHALL have ports: phase_secs  out  5  seconds elapsed in current phase.
REQ-008 SHALL have ports: last_secs  out  5  duration of the previous phase.
REQ-009 SHALL have ports: conflict  out  1  illegal lamp pattern detected.
REQ-010 SHALL have ports: sequence_err  out  1  illegal phase-to-phase transition detected.
REQ-011 SHALL have ports: fail_safe  out  1  fault-latched indication (see Configuration).

Function
REQ-012 SHALL register the seven lamp inputs once; all decode acts on the registered copy (1-cycle input latency).
REQ-013 SHALL decode: 0 NONE; 1 ALL_RED (Rm,Rs); 2 MAIN_GREEN (Gm,Rs); 3 MAIN_YELLOW (Ym,Rs); 4 SIDE_GREEN (Rm,Gs); 5 SIDE_YELLOW (Rm,Ys); 6 WALK (Rm,Rs,W); 7 ILLEGAL (any other pattern, including W with any green/yellow and any two lamps of one road).
REQ-014 SHALL update phase one cycle after the registered pattern changes (2 cycles total from input), asserting phase_change for exactly that cycle.
REQ-015 SHALL assert conflict for every cycle phase equals ILLEGAL (combinational from phase, so same cycle).
REQ-016 SHALL accept transitions: ALL_RED->MAIN_GREEN, MAIN_GREEN->MAIN_YELLOW, MAIN_YELLOW->SIDE_GREEN, MAIN_YELLOW->WALK, WALK->SIDE_GREEN, SIDE_GREEN->SIDE_YELLOW, SIDE_YELLOW->MAIN_GREEN.
REQ-017 SHALL pulse sequence_err for one cycle, coincident with phase_change, on any other transition between two legal phases.
REQ-018 SHALL exempt from sequence checking any transition out of NONE or ILLEGAL and any transition into ILLEGAL.
REQ-019 SHALL increment phase_secs on one_hz_enable, saturating at 31.
REQ-020 SHALL, on phase_change, load last_secs with the old phase_secs and clear phase_secs to 0; a tick coinciding with phase_change is dropped.
REQ-021 SHALL leave phase, phase_secs and last_secs unchanged while the registered pattern is stable, apart from ticks.

Reset
REQ-022 SHALL, on reset, set phase=NONE, phase_change=0, phase_secs=0, last_secs=0, conflict=0, sequence_err=0, fail_safe=0, and clear the input register to all zeros.
REQ-023 SHALL let reset override all other activity in the same cycle, including a pending phase change or tick.

Configuration
REQ-024 SHALL honour macro TLM_FAULT_LATCH_EN: when defined, fail_safe sets on any conflict or sequence_err and holds until reset.
REQ-025 SHALL, without TLM_FAULT_LATCH_EN, tie fail_safe to 0 and keep conflict/sequence_err non-sticky as specified above.

Structure
REQ-026 SHALL place phase code constants (NONE..ILLEGAL) and the 5-bit seconds width in shared package tl_pkg, which the controller also uses.
REQ-027 SHALL implement the pattern decode as sub-module tl_phase_decode (pure combinational, 7 in, 3 out); sequencing, counters and fault latch stay in the top.

Verification
REQ-028 SHALL cover: reset, then drive Rm,Rs -> phase=1 two cycles later, phase_change pulse, sequence_err=0.
REQ-029 SHALL cover: full cycle 1->2->3->6->4->5->2 with 3 ticks per phase -> no sequence_err; last_secs=3 at each change.
REQ-030 SHALL cover: MAIN_GREEN then SIDE_GREEN directly -> one-cycle sequence_err with phase_change; fail_safe=1 and held only with TLM_FAULT_LATCH_EN.
REQ-031 SHALL cover: Gm and Gs together -> phase=7, conflict=1 while held; return to Rm,Rs -> conflict=0, no sequence_err.
REQ-032 SHALL cover: 40 ticks in one phase -> phase_secs=31 saturated; tick on the same cycle as phase_change -> new phase_secs=0, last_secs=31.
REQ-033 SHALL cover: reset asserted mid-phase with phase_secs=7 -> all outputs return to reset values next cycle.
